// File: rtl/pattern_arbiter.sv
// Round-robin arbiter sharing one 3-bit pattern generator among N_REQ requesters.
// Each grant runs a burst of req_len patterns. The generator enable is low for at least
// one edge between bursts, so every burst restarts the generator sequence.
module pattern_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  input  logic [2:0]             gen_q,
  output logic                   gen_en,
  output logic [N_REQ-1:0]       grant,
  output logic [2:0]             pat_out,
  output logic                   pat_valid,
  output logic                   done
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StLast = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [LEN_W:0]   rem_q, rem_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             gen_en_q;
  logic             pat_valid_q;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [LEN_W-1:0] pick_len;

  // Round-robin search: first set request at or above rr_ptr, wrapping around.
  always_comb begin
    int unsigned cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(rr_ptr_q) + i) % N_REQ;
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign pick_len = req_len[pick_idx*LEN_W +: LEN_W];

  // Burst sequencing; requests are only sampled in idle so a running burst always completes.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    winner_d = winner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d  = StRun;
          winner_d = pick_idx;
          // A zero length field stands for the full 2**LEN_W burst.
          rem_d    = (pick_len == '0) ? (LEN_W+1)'(1) << LEN_W : {1'b0, pick_len};
        end
      end
      StRun: begin
        rem_d = rem_q - 1'b1;
        if (rem_q == (LEN_W+1)'(1)) begin
          state_d = StLast;
        end
      end
      StLast: begin
        state_d  = StIdle;
        rr_ptr_d = (winner_q == IDX_W'(N_REQ-1)) ? '0 : winner_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; gen_en is a flop so the generator sees a clean enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      winner_q    <= '0;
      rr_ptr_q    <= '0;
      gen_en_q    <= 1'b0;
      pat_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      winner_q    <= winner_d;
      rr_ptr_q    <= rr_ptr_d;
      gen_en_q    <= (state_d == StRun);
      // Generator output lags its enable by one edge.
      pat_valid_q <= gen_en_q;
    end
  end

  // Outputs decoded from registered state; pat_out is a combinational gate on gen_q.
  always_comb begin
    grant = '0;
    if (state_q == StRun || state_q == StLast) begin
      grant = {{(N_REQ-1){1'b0}}, 1'b1} << winner_q;
    end
    gen_en    = gen_en_q;
    pat_valid = pat_valid_q;
    done      = (state_q == StLast);
    pat_out   = pat_valid_q ? gen_q : 3'b000;
  end

endmodule

// File: tb/tb_pattern_arbiter.sv
// Directed bench for pattern_arbiter with a behavioural pattern generator attached.
module tb_pattern_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] req_len = '0;
  logic [2:0]  gen_q;
  logic        gen_en;
  logic [3:0]  grant;
  logic [2:0]  pat_out;
  logic        pat_valid;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pattern_arbiter #(.N_REQ(4), .LEN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_len   (req_len),
    .gen_q     (gen_q),
    .gen_en    (gen_en),
    .grant     (grant),
    .pat_out   (pat_out),
    .pat_valid (pat_valid),
    .done      (done)
  );

  // Generator model: cleared while disabled, then 001,011,100,010 repeating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) gen_q <= 3'b000;
    else if (!gen_en) gen_q <= 3'b000;
    else begin
      case (gen_q)
        3'b000:  gen_q <= 3'b001;
        3'b001:  gen_q <= 3'b011;
        3'b011:  gen_q <= 3'b100;
        3'b100:  gen_q <= 3'b010;
        3'b010:  gen_q <= 3'b001;
        default: gen_q <= 3'b000;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] pat(input int i);
    case (i % 4)
      0:       return 3'b001;
      1:       return 3'b011;
      2:       return 3'b100;
      default: return 3'b010;
    endcase
  endfunction

  task automatic set_len(input int idx, input int v);
    req_len[idx*4 +: 4] = v[3:0];
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_gen_en"}, 32'(gen_en), 32'h0);
    chk({tag, "_valid"}, 32'(pat_valid), 32'h0);
    chk({tag, "_pat"}, 32'(pat_out), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
  endtask

  // Called in the first RUN cycle; walks the burst and ends in the following idle cycle.
  task automatic burst(input string tag, input logic [3:0] g, input int n);
    chk({tag, "_run1_grant"}, 32'(grant), 32'(g));
    chk({tag, "_run1_gen_en"}, 32'(gen_en), 32'h1);
    chk({tag, "_run1_valid"}, 32'(pat_valid), 32'h0);
    chk({tag, "_run1_pat"}, 32'(pat_out), 32'h0);
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("%s_p%0d_valid", tag, i), 32'(pat_valid), 32'h1);
      chk($sformatf("%s_p%0d_pat", tag, i), 32'(pat_out), 32'(pat(i)));
      chk($sformatf("%s_p%0d_done", tag, i), 32'(done), 32'(i == n - 1));
      chk($sformatf("%s_p%0d_gen_en", tag, i), 32'(gen_en), 32'(i != n - 1));
      chk($sformatf("%s_p%0d_grant", tag, i), 32'(grant), 32'(g));
    end
    step();
    chk({tag, "_idle_grant"}, 32'(grant), 32'h0);
    chk({tag, "_idle_valid"}, 32'(pat_valid), 32'h0);
    chk({tag, "_idle_done"}, 32'(done), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    #1;
    chk_quiet("rst_async");
    step();
    chk_quiet("rst_held");
    rst = 1'b0;
    step();
  endtask

  initial begin
    // Reset state
    step();
    chk_quiet("reset");
    rst = 1'b0;
    step();
    chk_quiet("idle_no_req");

    // 1: requester 0, len 3; dropping req after the grant is harmless
    req = 4'b0001; set_len(0, 3);
    step();
    req = '0;
    burst("t1", 4'b0001, 3);

    // 2: requester 1, len 6, then stays idle
    req = 4'b0010; set_len(1, 6);
    step();
    req = '0;
    burst("t2", 4'b0010, 6);
    step();
    chk_quiet("t2_stay_idle");

    // 3: all requesting with len 1, round-robin from a fresh pointer
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) set_len(k, 1);
    for (int b = 0; b < 5; b++) begin
      step();
      if (b == 4) req = '0;
      burst($sformatf("t3_b%0d", b), 4'b0001 << (b % 4), 1);
    end

    // 4: len field 0 means 16 patterns
    req = 4'b0100; set_len(2, 0);
    step();
    req = '0;
    burst("t4", 4'b0100, 16);

    // 5: reset in the middle of a burst, then a fresh burst restarts at 001
    req = 4'b0001; set_len(0, 5);
    step();
    req = '0;
    step();
    chk("t5_p0", 32'(pat_out), 32'h1);
    step();
    chk("t5_p1", 32'(pat_out), 32'h3);
    rst = 1'b1;
    #1;
    chk_quiet("t5_async");
    step();
    chk_quiet("t5_held");
    rst = 1'b0;
    req = 4'b0001; set_len(0, 2);
    step();
    req = '0;
    burst("t5_re", 4'b0001, 2);

    // 6: req0 pulses for one cycle, req1 arrives mid-burst and waits its turn
    req = 4'b0001; set_len(0, 4); set_len(1, 1);
    step();
    req = 4'b0010;
    burst("t6_r0", 4'b0001, 4);
    step();
    req = '0;
    burst("t6_r1", 4'b0010, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
